// File: rtl/mlp_infer_sequencer.sv
// Feeds a slow combinational MLP classifier: deserialises a feature frame, holds it while the
// classifier settles, then captures the argmax class onto a result stream. One inference in flight.
module mlp_infer_sequencer #(
    parameter int N_FEAT     = 11,
    parameter int FEAT_W     = 4,
    parameter int CLS_W      = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FEAT_W-1:0]          s_data,
    input  logic                       s_last,
    output logic [N_FEAT*FEAT_W-1:0]   cls_inp,
    input  logic [CLS_W-1:0]           cls_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CLS_W-1:0]           m_class,
    output logic                       frame_err
);
    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_FEAT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        HOLD    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // All sequencer state in one struct so it can be probed as a unit.
    typedef struct packed {
        state_t             state;
        logic [IDX_W-1:0]   idx;
        logic [CNT_W-1:0]   cnt;
        logic               resync;
    } seq_t;

    seq_t seq;

    // Both ports: a transfer happens on a rising edge where valid && ready are both 1;
    // valid is never withdrawn by the sequencer until its transfer completes.
    logic s_fire;
    logic m_fire;
    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq.state  <= COLLECT;
            seq.idx    <= '0;
            seq.cnt    <= '0;
            seq.resync <= 1'b0;
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            m_class    <= '0;
            cls_inp    <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (seq.state)
                COLLECT: begin
                    if (s_fire) begin
                        for (int k = 0; k < N_FEAT; k++) begin
                            if (seq.idx == IDX_W'(k)) begin
                                cls_inp[k*FEAT_W +: FEAT_W] <= s_data;
                            end
                        end
                        if (seq.idx == LAST_IDX) begin
                            // A full frame always classifies; a missing s_last only forces a resync.
                            seq.state <= SETTLE;
                            seq.cnt   <= SETTLE_LD;
                            s_ready   <= 1'b0;
                            if (!s_last) begin
                                frame_err  <= 1'b1;
                                seq.resync <= 1'b1;
                            end
                        end else if (s_last) begin
                            frame_err <= 1'b1;
                            seq.idx   <= '0;
                        end else begin
                            seq.idx <= seq.idx + IDX_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (seq.cnt == '0) begin
                        m_class   <= cls_out;
                        m_valid   <= 1'b1;
                        seq.state <= HOLD;
                    end else begin
                        seq.cnt <= seq.cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (m_fire) begin
                        m_valid   <= 1'b0;
                        seq.idx   <= '0;
                        s_ready   <= 1'b1;
                        seq.state <= seq.resync ? DRAIN : COLLECT;
                    end
                end
                DRAIN: begin
                    if (s_fire && s_last) begin
                        seq.resync <= 1'b0;
                        seq.idx    <= '0;
                        seq.state  <= COLLECT;
                    end
                end
                default: begin
                    seq.state <= COLLECT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_infer_sequencer.sv
// Directed and randomized bench for mlp_infer_sequencer; a hash of the frame stands in for the classifier.
module tb_mlp_infer_sequencer;
    localparam int N_FEAT        = 11;
    localparam int FEAT_W        = 4;
    localparam int CLS_W         = 3;
    localparam int SETTLE_CYC    = 4;
    localparam int INP_W         = N_FEAT * FEAT_W;
    localparam int N_RAND_FRAMES = 1000;
    localparam int RAND_BUDGET   = 60000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic [INP_W-1:0]  cls_inp;
    logic [CLS_W-1:0]  cls_out;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [CLS_W-1:0]  m_class;
    logic              frame_err;

    logic              stub_mode = 1'b1;
    logic [CLS_W-1:0]  stub_val = '0;

    int checks = 0;
    int errors = 0;
    int fe_count = 0;
    int mv_rises = 0;
    logic mv_prev = 1'b0;

    logic [CLS_W-1:0] exp_q[$];
    logic [INP_W-1:0] frame_q[$];

    mlp_infer_sequencer #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cls_inp(cls_inp), .cls_out(cls_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .frame_err(frame_err)
    );

    // Classifier stand-in: a class derived from every feature, so a lost or extra beat changes it.
    function automatic logic [CLS_W-1:0] ref_class(input logic [INP_W-1:0] v);
        logic [7:0] acc;
        acc = 8'd0;
        for (int k = 0; k < N_FEAT; k++) begin
            acc = acc * 8'd3 + {4'd0, v[FEAT_W*k +: FEAT_W]};
        end
        return acc[CLS_W-1:0];
    endfunction

    function automatic logic [INP_W-1:0] rand_frame();
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom();
        b = $urandom();
        return INP_W'({a, b});
    endfunction

    assign cls_out = stub_mode ? stub_val : ref_class(cls_inp);

    // clock / reset block
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_count <= fe_count + 1;
        if (m_valid === 1'b1 && mv_prev !== 1'b1) mv_rises <= mv_rises + 1;
        mv_prev <= m_valid;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic send_beat(input logic [FEAT_W-1:0] d, input logic l);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!acc && n < 100) begin
            acc = (s_ready === 1'b1);
            tick();
            n++;
        end
        check("beat_accept", 64'(acc), 64'(1));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [INP_W-1:0] f, input int n_beats, input int last_idx);
        for (int k = 0; k < n_beats; k++) begin
            send_beat(f[FEAT_W*k +: FEAT_W], k == last_idx);
        end
    endtask

    task automatic wait_mvalid(input string tag, output int n);
        n = 0;
        while (m_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(m_valid), 64'(1));
    endtask

    task automatic wait_result(input string tag, input logic [CLS_W-1:0] exp_cls,
                               input logic [INP_W-1:0] exp_inp);
        int n;
        m_ready = 1'b0;
        wait_mvalid({tag, "_mvalid"}, n);
        check({tag, "_class"}, 64'(m_class), 64'(exp_cls));
        check({tag, "_inp"}, 64'(cls_inp), 64'(exp_inp));
        m_ready = 1'b1;
        tick();
        check({tag, "_release"}, 64'(m_valid), 64'(0));
        m_ready = 1'b0;
    endtask

    initial begin
        int n;
        int fe0;
        int mv0;
        logic [INP_W-1:0] f;
        logic [INP_W-1:0] cur;
        int fpos;
        int sent;
        int done;
        int cyc;
        logic sr;
        logic mv;
        logic sv;
        logic mr;
        logic [CLS_W-1:0] mc;
        logic [INP_W-1:0] ci;

        // reset
        rst = 1'b1;
        repeat (3) tick();
        check("rst_s_ready", 64'(s_ready), 64'(1));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_class", 64'(m_class), 64'(0));
        check("rst_cls_inp", 64'(cls_inp), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        rst = 1'b0;
        tick();

        // 1) single frame 1..11, stub class 5
        stub_mode = 1'b1;
        stub_val  = 3'd5;
        m_ready   = 1'b1;
        for (int k = 0; k < N_FEAT; k++) f[FEAT_W*k +: FEAT_W] = FEAT_W'(k + 1);
        send_frame(f, N_FEAT, N_FEAT - 1);
        check("t1_cls_inp", 64'(cls_inp), 64'(44'hBA987654321));
        check("t1_settle_s_ready", 64'(s_ready), 64'(0));
        wait_mvalid("t1_mvalid", n);
        // Last beat is accepted at edge t; m_valid is first seen in cycle t+SETTLE_CYC+1.
        check("t1_latency", 64'(n), 64'(SETTLE_CYC));
        check("t1_class", 64'(m_class), 64'(5));
        check("t1_hold_s_ready", 64'(s_ready), 64'(0));
        tick();
        check("t1_release", 64'(m_valid), 64'(0));
        check("t1_s_ready_next", 64'(s_ready), 64'(1));
        m_ready = 1'b0;

        // 2) backpressure in HOLD, classifier output changes mid-hold
        stub_val = 3'd2;
        f = rand_frame();
        send_frame(f, N_FEAT, N_FEAT - 1);
        wait_mvalid("t2_mvalid", n);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) stub_val = 3'd6;
            check("t2_hold_valid", 64'(m_valid), 64'(1));
            check("t2_hold_class", 64'(m_class), 64'(2));
            check("t2_hold_s_ready", 64'(s_ready), 64'(0));
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("t2_release", 64'(m_valid), 64'(0));
        check("t2_s_ready", 64'(s_ready), 64'(1));
        m_ready = 1'b0;

        // 3) early s_last on beat 4
        stub_mode = 1'b0;
        fe0 = fe_count;
        mv0 = mv_rises;
        send_frame(rand_frame(), 5, 4);
        check("t3_err_pulse", 64'(frame_err), 64'(1));
        tick();
        check("t3_err_clear", 64'(frame_err), 64'(0));
        repeat (6) tick();
        check("t3_err_count", 64'(fe_count - fe0), 64'(1));
        check("t3_no_result", 64'(mv_rises - mv0), 64'(0));
        f = rand_frame();
        send_frame(f, N_FEAT, N_FEAT - 1);
        wait_result("t3_next", ref_class(f), f);

        // 4) missing s_last, then three junk beats
        fe0 = fe_count;
        f = rand_frame();
        send_frame(f, N_FEAT, -1);
        check("t4_err_pulse", 64'(frame_err), 64'(1));
        wait_result("t4_result", ref_class(f), f);
        send_beat(4'hF, 1'b0);
        send_beat(4'h0, 1'b0);
        send_beat(4'h9, 1'b1);
        check("t4_junk_ignored", 64'(cls_inp), 64'(f));
        repeat (2) tick();
        check("t4_err_count", 64'(fe_count - fe0), 64'(1));
        f = rand_frame();
        send_frame(f, N_FEAT, N_FEAT - 1);
        wait_result("t4_clean", ref_class(f), f);

        // 5a) reset mid-SETTLE
        send_frame(rand_frame(), N_FEAT, N_FEAT - 1);
        tick();
        rst = 1'b1;
        tick();
        check("t5s_m_valid", 64'(m_valid), 64'(0));
        check("t5s_m_class", 64'(m_class), 64'(0));
        check("t5s_cls_inp", 64'(cls_inp), 64'(0));
        check("t5s_s_ready", 64'(s_ready), 64'(1));
        rst = 1'b0;
        mv0 = mv_rises;
        repeat (10) tick();
        check("t5s_no_stale", 64'(mv_rises - mv0), 64'(0));

        // 5b) reset mid-HOLD
        stub_mode = 1'b1;
        stub_val  = 3'd7;
        send_frame(rand_frame(), N_FEAT, N_FEAT - 1);
        wait_mvalid("t5h_mvalid", n);
        check("t5h_class", 64'(m_class), 64'(7));
        rst = 1'b1;
        tick();
        check("t5h_m_valid", 64'(m_valid), 64'(0));
        check("t5h_m_class", 64'(m_class), 64'(0));
        check("t5h_cls_inp", 64'(cls_inp), 64'(0));
        check("t5h_s_ready", 64'(s_ready), 64'(1));
        rst = 1'b0;
        stub_mode = 1'b0;
        mv0 = mv_rises;
        repeat (10) tick();
        check("t5h_no_stale", 64'(mv_rises - mv0), 64'(0));

        // 6) random gaps on both ports, scoreboard against the classifier stand-in
        cur  = rand_frame();
        fpos = 0;
        sent = 0;
        done = 0;
        cyc  = 0;
        while (done < N_RAND_FRAMES && cyc < RAND_BUDGET) begin
            sr = s_ready;
            mv = m_valid;
            mc = m_class;
            ci = cls_inp;
            sv = (sent < N_RAND_FRAMES) && ($urandom_range(0, 3) != 0);
            s_valid = sv;
            s_data  = sv ? cur[FEAT_W*fpos +: FEAT_W] : FEAT_W'($urandom());
            s_last  = sv ? (fpos == N_FEAT - 1) : 1'($urandom());
            mr = ($urandom_range(0, 1) == 1);
            m_ready = mr;
            tick();
            cyc++;
            if (sv && sr === 1'b1) begin
                fpos++;
                if (fpos == N_FEAT) begin
                    exp_q.push_back(ref_class(cur));
                    frame_q.push_back(cur);
                    sent++;
                    cur  = rand_frame();
                    fpos = 0;
                end
            end
            if (mv === 1'b1 && mr) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_result", 64'(1), 64'(0));
                end else begin
                    check("rand_class", 64'(mc), 64'(exp_q.pop_front()));
                    check("rand_inp", 64'(ci), 64'(frame_q.pop_front()));
                end
                done++;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        check("rand_frames_done", 64'(done), 64'(N_RAND_FRAMES));
        check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
